// File: rtl/mc_port_responder_if.sv
// mc_port_responder_if
// Purpose: request/response bundle between a memory-port requester and
//          mc_port_responder.
// Signals:
//   req_ld, req_st    load / store strobes
//   req_size          access size code (0=1B, 1=2B, 2=4B, 3=8B)
//   req_vadr          byte address
//   req_wrd_rdctl     store data, or load read-control in bits [31:0]
//   req_flush         flush request
//   rsp_stall         requester cannot take responses this cycle
//   rd_rq_stall       load back-pressure
//   wr_rq_stall       store back-pressure
//   rsp_push          load response valid
//   rsp_data          load response data
//   rsp_rdctl         load response read-control
//   rsp_flush_cmplt   one-cycle flush completion
//   o_err             sticky errors {both, misalign, overflow}
interface mc_port_responder_if;
  logic        req_ld;
  logic        req_st;
  logic [1:0]  req_size;
  logic [47:0] req_vadr;
  logic [63:0] req_wrd_rdctl;
  logic        req_flush;
  logic        rsp_stall;
  logic        rd_rq_stall;
  logic        wr_rq_stall;
  logic        rsp_push;
  logic [63:0] rsp_data;
  logic [31:0] rsp_rdctl;
  logic        rsp_flush_cmplt;
  logic [2:0]  o_err;

  modport master (
    output req_ld, req_st, req_size, req_vadr, req_wrd_rdctl, req_flush, rsp_stall,
    input  rd_rq_stall, wr_rq_stall, rsp_push, rsp_data, rsp_rdctl, rsp_flush_cmplt, o_err
  );

  modport slave (
    input  req_ld, req_st, req_size, req_vadr, req_wrd_rdctl, req_flush, rsp_stall,
    output rd_rq_stall, wr_rq_stall, rsp_push, rsp_data, rsp_rdctl, rsp_flush_cmplt, o_err
  );
endinterface

// File: rtl/mc_port_responder.sv
// mc_port_responder
// Purpose: 64-bit word memory answering byte-sized loads/stores. Loads are
//          read at accept, pass a LAT-stage delay line and a response FIFO,
//          and come back in accept order. A flush FSM stalls the requester
//          until every in-flight load has been returned.
// Ports:
//   clk        single clock, posedge
//   i_reset_n  synchronous active-low reset
//   bus        mc_port_responder_if.slave (request/response bundle)
//
// state | meaning
// IDLE  | normal operation
// DRAIN | flush requested, requester stalled until inflight reaches zero
// DONE  | rsp_flush_cmplt asserted for one cycle
module mc_port_responder #(
  parameter int AW    = 8,
  parameter int DEPTH = 8,
  parameter int LAT   = 4
) (
  input logic                 clk,
  input logic                 i_reset_n,
  mc_port_responder_if.slave  bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

  state_t        state, state_nx;
  logic [63:0]   mem [2**AW];
  logic [AW-1:0] widx;
  logic [2:0]    boff;
  logic [5:0]    bit_sh;
  logic [7:0]    len_mask, sh_mask;
  logic [2:0]    align_mask;
  logic [63:0]   len_bits, wr_bits, rd_data;
  logic          misalign, ld_acc, st_acc, pop, flush_cmplt;
  logic [CW-1:0] inflight, inflight_nx, fifo_cnt;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LAT-1:0] dl_vld;
  logic [95:0]   dl_dat [LAT];
  logic [95:0]   fifo [DEPTH];
  logic          rd_stall_q, wr_stall_q;
  logic [2:0]    err_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign widx   = bus.req_vadr[AW+2:3];
  assign boff   = bus.req_vadr[2:0];
  assign bit_sh = {boff, 3'b000};

  always_comb begin
    len_mask   = 8'h01;
    align_mask = 3'b000;
    case (bus.req_size)
      2'd0: begin len_mask = 8'h01; align_mask = 3'b000; end
      2'd1: begin len_mask = 8'h03; align_mask = 3'b001; end
      2'd2: begin len_mask = 8'h0f; align_mask = 3'b011; end
      default: begin len_mask = 8'hff; align_mask = 3'b111; end
    endcase
    // Bytes shifted past byte 7 fall off: misaligned accesses are truncated.
    sh_mask  = len_mask << boff;
    len_bits = '0;
    wr_bits  = '0;
    for (int b = 0; b < 8; b++) begin
      len_bits[8*b +: 8] = {8{len_mask[b]}};
      wr_bits[8*b +: 8]  = {8{sh_mask[b]}};
    end
  end

  assign misalign = (boff & align_mask) != 3'b000;
  assign ld_acc   = i_reset_n & bus.req_ld & (inflight != CW'(DEPTH));
  assign st_acc   = i_reset_n & bus.req_st & ~bus.req_ld;
  assign rd_data  = (mem[widx] >> bit_sh) & len_bits;
  assign pop      = i_reset_n & (fifo_cnt != '0) & ~bus.rsp_stall;
  assign inflight_nx = inflight + CW'(ld_acc) - CW'(pop);

  // Memory is deliberately not reset.
  always_ff @(posedge clk) begin
    if (st_acc)
      mem[widx] <= (mem[widx] & ~wr_bits) | ((bus.req_wrd_rdctl << bit_sh) & wr_bits);
  end

  always_ff @(posedge clk) begin
    if (!i_reset_n) dl_vld <= '0;
    else begin
      dl_vld[0] <= ld_acc;
      for (int i = 1; i < LAT; i++) dl_vld[i] <= dl_vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    dl_dat[0] <= {rd_data, bus.req_wrd_rdctl[31:0]};
    for (int i = 1; i < LAT; i++) dl_dat[i] <= dl_dat[i-1];
    if (dl_vld[LAT-1]) fifo[wr_ptr] <= dl_dat[LAT-1];
  end

  // inflight <= DEPTH always, so the FIFO can never overflow.
  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      inflight <= '0;
    end else begin
      if (dl_vld[LAT-1]) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      fifo_cnt <= fifo_cnt + CW'(dl_vld[LAT-1]) - CW'(pop);
      inflight <= inflight_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    flush_cmplt = 1'b0;
    case (state)
      IDLE:  if (bus.req_flush) state_nx = DRAIN;
      // Looking at the next count lets completion follow the final response directly.
      DRAIN: if (inflight_nx == '0) state_nx = DONE;
      DONE: begin
        flush_cmplt = 1'b1;
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      rd_stall_q <= 1'b0;
      wr_stall_q <= 1'b0;
      err_q      <= '0;
    end else begin
      // Threshold DEPTH-2 leaves a two-request skid for the requester.
      rd_stall_q <= (inflight_nx >= CW'(DEPTH - 2)) | (state_nx == DRAIN);
      wr_stall_q <= (state_nx == DRAIN);
      err_q <= err_q | {bus.req_ld & bus.req_st,
                        (ld_acc | st_acc) & misalign,
                        bus.req_ld & (inflight == CW'(DEPTH))};
    end
  end

  assign bus.rd_rq_stall     = rd_stall_q;
  assign bus.wr_rq_stall     = wr_stall_q;
  assign bus.o_err           = err_q;
  assign bus.rsp_push        = pop;
  assign bus.rsp_data        = pop ? fifo[rd_ptr][95:32] : '0;
  assign bus.rsp_rdctl       = pop ? fifo[rd_ptr][31:0] : '0;
  assign bus.rsp_flush_cmplt = i_reset_n & flush_cmplt;

endmodule

// File: tb/tb_mc_port_responder.sv
// tb_mc_port_responder
// Purpose: directed self-checking bench for mc_port_responder (default
//          parameters AW=8, DEPTH=8, LAT=4).
// Ports: none.
module tb_mc_port_responder;
  logic clk;
  logic i_reset_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  mc_port_responder_if bus();

  mc_port_responder dut (
    .clk       (clk),
    .i_reset_n (i_reset_n),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr_req();
    bus.req_ld        = 1'b0;
    bus.req_st        = 1'b0;
    bus.req_flush     = 1'b0;
    bus.req_size      = 2'd0;
    bus.req_vadr      = '0;
    bus.req_wrd_rdctl = '0;
  endtask

  task automatic set_req(input logic ld, input logic st, input logic [1:0] size,
                         input logic [47:0] adr, input logic [63:0] wd);
    bus.req_ld        = ld;
    bus.req_st        = st;
    bus.req_size      = size;
    bus.req_vadr      = adr;
    bus.req_wrd_rdctl = wd;
  endtask

  task automatic wait_rsp(input string tag, input logic [63:0] exp_d, input logic [31:0] exp_c);
    int n = 0;
    while (bus.rsp_push !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_push"}, 64'(bus.rsp_push), 64'd1);
    chk({tag, "_data"}, bus.rsp_data, exp_d);
    chk({tag, "_rdctl"}, 64'(bus.rsp_rdctl), 64'(exp_c));
    tick();
  endtask

  task automatic do_reset(input int cycles);
    i_reset_n = 1'b0;
    for (int i = 0; i < cycles; i++) tick();
    i_reset_n = 1'b1;
  endtask

  initial begin
    logic [63:0] exp_b [8];
    exp_b = '{64'h88, 64'h77, 64'h66, 64'h55, 64'h44, 64'h33, 64'h22, 64'h11};
    clr_req();
    bus.rsp_stall = 1'b0;
    i_reset_n = 1'b0;
    #1;

    // Reset with a load presented: must be ignored.
    set_req(1'b1, 1'b0, 2'd3, 48'h40, 64'h1);
    for (int i = 0; i < 3; i++) tick();
    chk("rst_push", 64'(bus.rsp_push), 64'd0);
    chk("rst_data", bus.rsp_data, 64'd0);
    chk("rst_rd_stall", 64'(bus.rd_rq_stall), 64'd0);
    chk("rst_wr_stall", 64'(bus.wr_rq_stall), 64'd0);
    chk("rst_cmplt", 64'(bus.rsp_flush_cmplt), 64'd0);
    chk("rst_err", 64'(bus.o_err), 64'd0);
    clr_req();
    i_reset_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("rst_ld_ignored", 64'(bus.rsp_push), 64'd0);

    // Store 8B then 1B load @0x43: response exactly LAT cycles after accept.
    set_req(1'b0, 1'b1, 2'd3, 48'h40, 64'h1122334455667788);
    tick();
    set_req(1'b1, 1'b0, 2'd0, 48'h43, 64'h5);
    tick();
    clr_req();
    for (int i = 0; i < 3; i++) tick();
    chk("lat_early_push", 64'(bus.rsp_push), 64'd0);
    chk("lat_early_data", bus.rsp_data, 64'd0);
    tick();
    chk("lat_push", 64'(bus.rsp_push), 64'd1);
    chk("lat_data", bus.rsp_data, 64'h55);
    chk("lat_rdctl", 64'(bus.rsp_rdctl), 64'h5);
    tick();
    chk("lat_popped", 64'(bus.rsp_push), 64'd0);

    // Back-to-back loads of different sizes, returned in order.
    set_req(1'b1, 1'b0, 2'd1, 48'h44, 64'h7);
    tick();
    set_req(1'b1, 1'b0, 2'd2, 48'h40, 64'h8);
    tick();
    clr_req();
    wait_rsp("b2b0", 64'h3344, 32'h7);
    wait_rsp("b2b1", 64'h55667788, 32'h8);
    chk("b2b_err", 64'(bus.o_err), 64'd0);

    // Misaligned stores with truncation, then ld&st together.
    set_req(1'b0, 1'b1, 2'd3, 48'h00, 64'h0);
    tick();
    set_req(1'b0, 1'b1, 2'd2, 48'h02, 64'hAABBCCDD);
    tick();
    chk("mis_err", 64'(bus.o_err), 64'h2);
    set_req(1'b0, 1'b1, 2'd2, 48'h06, 64'h11223344);
    tick();
    set_req(1'b1, 1'b0, 2'd3, 48'h00, 64'h31);
    tick();
    clr_req();
    wait_rsp("trunc_word", 64'h3344AABBCCDD0000, 32'h31);
    set_req(1'b1, 1'b0, 2'd2, 48'h06, 64'h32);
    tick();
    clr_req();
    wait_rsp("trunc_ld", 64'h3344, 32'h32);
    set_req(1'b1, 1'b1, 2'd3, 48'h00, 64'hFFFFFFFFFFFFFFFF);
    bus.req_wrd_rdctl = 64'hFFFFFFFF00000033;
    tick();
    clr_req();
    chk("both_err", 64'(bus.o_err), 64'h6);
    wait_rsp("both_ld", 64'h3344AABBCCDD0000, 32'h33);
    set_req(1'b1, 1'b0, 2'd3, 48'h00, 64'h34);
    tick();
    clr_req();
    wait_rsp("both_st_ignored", 64'h3344AABBCCDD0000, 32'h34);

    // Fill to DEPTH with responses stalled, then drain in order.
    do_reset(1);
    chk("fill_err_clr", 64'(bus.o_err), 64'd0);
    bus.rsp_stall = 1'b1;
    for (int k = 0; k < 8; k++) begin
      set_req(1'b1, 1'b0, 2'd0, 48'h40 + 48'(k), 64'h100 + 64'(k));
      tick();
      chk($sformatf("fill_rd_stall%0d", k), 64'(bus.rd_rq_stall), (k >= 5) ? 64'd1 : 64'd0);
    end
    chk("fill_wr_stall", 64'(bus.wr_rq_stall), 64'd0);
    set_req(1'b1, 1'b0, 2'd0, 48'h47, 64'h1FF);
    tick();
    clr_req();
    chk("ovf_err", 64'(bus.o_err), 64'h1);
    for (int i = 0; i < 5; i++) tick();
    chk("fill_stalled_push", 64'(bus.rsp_push), 64'd0);
    bus.rsp_stall = 1'b0;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain_push%0d", k), 64'(bus.rsp_push), 64'd1);
      chk($sformatf("drain_data%0d", k), bus.rsp_data, exp_b[k]);
      chk($sformatf("drain_rdctl%0d", k), 64'(bus.rsp_rdctl), 64'h100 + 64'(k));
      tick();
    end
    chk("drain_empty", 64'(bus.rsp_push), 64'd0);
    chk("drain_rd_stall", 64'(bus.rd_rq_stall), 64'd0);

    // Flush with a load outstanding and responses stalled 10 cycles.
    bus.rsp_stall = 1'b1;
    set_req(1'b1, 1'b0, 2'd0, 48'h40, 64'h77);
    tick();
    clr_req();
    bus.req_flush = 1'b1;
    tick();
    bus.req_flush = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("flush_rd_stall%0d", i), 64'(bus.rd_rq_stall), 64'd1);
      chk($sformatf("flush_wr_stall%0d", i), 64'(bus.wr_rq_stall), 64'd1);
      chk($sformatf("flush_cmplt_early%0d", i), 64'(bus.rsp_flush_cmplt), 64'd0);
      bus.req_flush = (i == 3);
      tick();
    end
    bus.req_flush = 1'b0;
    bus.rsp_stall = 1'b0;
    #1;
    chk("flush_rsp_push", 64'(bus.rsp_push), 64'd1);
    chk("flush_rsp_data", bus.rsp_data, 64'h88);
    chk("flush_rsp_rdctl", 64'(bus.rsp_rdctl), 64'h77);
    chk("flush_cmplt_pre", 64'(bus.rsp_flush_cmplt), 64'd0);
    tick();
    chk("flush_cmplt", 64'(bus.rsp_flush_cmplt), 64'd1);
    chk("flush_after_push", 64'(bus.rsp_push), 64'd0);
    tick();
    chk("flush_cmplt_one", 64'(bus.rsp_flush_cmplt), 64'd0);
    chk("flush_wr_release", 64'(bus.wr_rq_stall), 64'd0);
    chk("flush_rd_release", 64'(bus.rd_rq_stall), 64'd0);

    // Reset with three loads in flight and a store presented during reset.
    for (int k = 0; k < 3; k++) begin
      set_req(1'b1, 1'b0, 2'd3, 48'h40, 64'h200 + 64'(k));
      tick();
    end
    set_req(1'b0, 1'b1, 2'd3, 48'h40, 64'hDEADBEEFDEADBEEF);
    i_reset_n = 1'b0;
    tick();
    tick();
    chk("rst2_push", 64'(bus.rsp_push), 64'd0);
    chk("rst2_rdctl", 64'(bus.rsp_rdctl), 64'd0);
    clr_req();
    i_reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rst2_no_rsp%0d", i), 64'(bus.rsp_push), 64'd0);
      tick();
    end
    set_req(1'b1, 1'b0, 2'd3, 48'h40, 64'h300);
    tick();
    clr_req();
    wait_rsp("rst2_mem_kept", 64'h1122334455667788, 32'h300);
    chk("rst2_err", 64'(bus.o_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
